// File: rtl/kws_pkg.sv
// Shared widths, saturation bounds and FSM encoding for the KWS CMVN stage.
package kws_pkg;

    localparam int unsigned KWS_DATA_W    = 16;
    localparam int unsigned KWS_FRAC_BITS = 8;
    localparam int unsigned KWS_NUM_FEAT  = 40;
    localparam int unsigned KWS_FRAME_W   = 8;

    localparam logic signed [KWS_DATA_W-1:0] KWS_SAT_MAX = {1'b0, {(KWS_DATA_W-1){1'b1}}};
    localparam logic signed [KWS_DATA_W-1:0] KWS_SAT_MIN = {1'b1, {(KWS_DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } cmvn_state_t;

endpackage

// File: rtl/kws_cmvn_dp.sv
// Two-stage (x - mean) * istd datapath with round-half-up and saturation.
// The whole pipeline advances together on adv_i; outputs hold while stalled.
module kws_cmvn_dp
    import kws_pkg::*;
#(
    parameter int unsigned DATA_W    = KWS_DATA_W,
    parameter int unsigned FRAC_BITS = KWS_FRAC_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    input  logic              valid_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] mean_i,
    input  logic [DATA_W-1:0] istd_i,
    output logic              out_valid_o,
    output logic              out_last_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              pipe_busy_o
);

    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned PROD_W = 2 * DATA_W + 1;

    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (FRAC_BITS - 1);

    logic                     v1_q;
    logic                     last1_q;
    logic signed [DIFF_W-1:0] diff_q;
    logic signed [DIFF_W-1:0] diff_d;
    logic signed [DATA_W-1:0] istd1_q;

    logic                     out_valid_q;
    logic                     out_last_q;
    logic [DATA_W-1:0]        out_data_q;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] rnd_c;
    logic signed [PROD_W-1:0] shr_c;
    logic [DATA_W-1:0]        sat_c;

    // Stage 1 arithmetic: widen by one bit so the subtraction cannot overflow.
    always_comb begin
        diff_d = $signed({x_i[DATA_W-1], x_i}) - $signed({mean_i[DATA_W-1], mean_i});
    end

    // Stage 2 arithmetic: full-width product, round half up, arithmetic shift, clamp.
    always_comb begin
        prod_c = $signed({{DATA_W{diff_q[DIFF_W-1]}}, diff_q})
               * $signed({{(DATA_W+1){istd1_q[DATA_W-1]}}, istd1_q});
        rnd_c  = prod_c + RND_HALF;
        shr_c  = rnd_c >>> FRAC_BITS;
        sat_c  = shr_c[DATA_W-1:0];
        if (shr_c > SAT_MAX) begin
            sat_c = SAT_MAX[DATA_W-1:0];
        end else if (shr_c < SAT_MIN) begin
            sat_c = SAT_MIN[DATA_W-1:0];
        end
    end

    // Pipeline registers; nothing moves unless the downstream can take a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            diff_q      <= '0;
            istd1_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (adv_i) begin
            v1_q        <= valid_i;
            last1_q     <= valid_i & last_i;
            if (valid_i) begin
                diff_q  <= diff_d;
                istd1_q <= istd_i;
            end
            out_valid_q <= v1_q;
            out_last_q  <= v1_q & last1_q;
            if (v1_q) begin
                out_data_q <= sat_c;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = out_data_q;
    assign pipe_busy_o = v1_q | out_valid_q;

endmodule

// File: rtl/kws_cmvn.sv
// Streaming cepstral mean/variance normalisation: control FSM, feature/frame
// counters and per-feature coefficient file around the arithmetic pipeline.
module kws_cmvn
    import kws_pkg::*;
#(
    parameter int unsigned DATA_W    = KWS_DATA_W,
    parameter int unsigned FRAC_BITS = KWS_FRAC_BITS,
    parameter int unsigned NUM_FEAT  = KWS_NUM_FEAT,
    parameter int unsigned FRAME_W   = KWS_FRAME_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmvn_en,
    input  logic [FRAME_W-1:0]          num_frames,
    input  logic                        coef_we,
    input  logic [$clog2(NUM_FEAT)-1:0] coef_addr,
    input  logic [DATA_W-1:0]           coef_mean,
    input  logic [DATA_W-1:0]           coef_istd,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned ADDR_W = $clog2(NUM_FEAT);
    localparam logic [DATA_W-1:0] ISTD_ONE = DATA_W'(1) << FRAC_BITS;

    cmvn_state_t        state_q;
    cmvn_state_t        state_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;

    logic [ADDR_W-1:0]  feat_idx_q;
    logic [ADDR_W-1:0]  feat_idx_d;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic [FRAME_W-1:0] frame_cnt_d;
    logic [FRAME_W-1:0] num_frames_q;
    logic [FRAME_W-1:0] num_frames_d;

    logic [DATA_W-1:0]  mean_q [NUM_FEAT];
    logic [DATA_W-1:0]  istd_q [NUM_FEAT];

    logic               adv_c;
    logic               start_c;
    logic               in_fire_c;
    logic               last_feat_c;
    logic               last_in_c;
    logic               coef_wr_c;
    logic               pipe_busy_c;

    // Handshake and counter decode shared by the FSM and the datapath.
    always_comb begin
        adv_c       = !(out_valid && !out_ready);
        in_ready    = (state_q == RUN) && adv_c;
        in_fire_c   = in_valid && in_ready;
        start_c     = (state_q == IDLE) && cmvn_en;
        last_feat_c = (feat_idx_q == ADDR_W'(NUM_FEAT - 1));
        last_in_c   = last_feat_c && (frame_cnt_q == (num_frames_q - FRAME_W'(1)));
        coef_wr_c   = coef_we && !busy_q
                   && ({1'b0, coef_addr} < (ADDR_W+1)'(NUM_FEAT));
    end

    // State register, with busy/done registered off the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmvn_en) begin
                    state_d = (num_frames != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (in_fire_c && last_in_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy_c) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode of the upcoming state so busy/done line up with it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            RUN, DRAIN: busy_d = 1'b1;
            DONE:       done_d = 1'b1;
            default:    ;
        endcase
    end

    // Feature index wraps per frame; frame count and target latch on start.
    always_comb begin
        feat_idx_d   = feat_idx_q;
        frame_cnt_d  = frame_cnt_q;
        num_frames_d = num_frames_q;
        if (start_c) begin
            num_frames_d = num_frames;
            feat_idx_d   = '0;
            frame_cnt_d  = '0;
        end else if (in_fire_c) begin
            if (last_feat_c) begin
                feat_idx_d  = '0;
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end else begin
                feat_idx_d  = feat_idx_q + ADDR_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_idx_q   <= '0;
            frame_cnt_q  <= '0;
            num_frames_q <= '0;
        end else begin
            feat_idx_q   <= feat_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            num_frames_q <= num_frames_d;
        end
    end

    // Coefficient file: identity transform after reset, writable only when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_FEAT; i++) begin
                mean_q[i] <= '0;
                istd_q[i] <= ISTD_ONE;
            end
        end else if (coef_wr_c) begin
            mean_q[coef_addr] <= coef_mean;
            istd_q[coef_addr] <= coef_istd;
        end
    end

    kws_cmvn_dp #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .adv_i       (adv_c),
        .valid_i     (in_fire_c),
        .last_i      (last_feat_c),
        .x_i         (in_data),
        .mean_i      (mean_q[feat_idx_q]),
        .istd_i      (istd_q[feat_idx_q]),
        .out_valid_o (out_valid),
        .out_last_o  (out_last),
        .out_data_o  (out_data),
        .pipe_busy_o (pipe_busy_c)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule
